// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//
// Brings the 100 MHz -> 20 MHz PLL from power-up to a stable system clock.
// Everything runs on REFERENCECLK. The block does four jobs:
//   - holds the PLL in reset for a fixed time on each acquisition attempt
//   - synchronizes and filters the PLL lock indication
//   - retries on timeout, and ends in a sticky fault once the retries run out
//   - stretches the downstream system reset past the point of lock acceptance
// Lock loss while running restarts the whole acquisition.
//
// Every output is decoded from the state/counters of the previous cycle and
// then registered. So each output change shows up one cycle after the state
// change that causes it.
//
// Ports
//   REFERENCECLK     in   100 MHz reference clock (only clock)
//   RESET            in   synchronous active-high reset
//   PLL_LOCK         in   asynchronous PLL lock, 2-flop synchronized here
//   PLL_RESETB       out  PLL reset, active low
//   SYS_RESET        out  active-high reset for the 20 MHz domain
//   READY            out  lock accepted and SYS_RESET released
//   FAULT            out  sticky, all acquisition retries exhausted
//   RETRY_COUNT      out  timeouts in the current acquisition sequence
//   LOCK_LOSS_COUNT  out  saturating count of lock losses seen in RUN
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES   = 100,
  parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYS_RESET_STRETCH   = 16
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  output logic       PLL_RESETB,
  output logic       SYS_RESET,
  output logic       READY,
  output logic       FAULT,
  output logic [1:0] RETRY_COUNT,
  output logic [7:0] LOCK_LOSS_COUNT
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 32'd1);
  localparam int TMO_W  = $clog2(LOCK_TIMEOUT_CYCLES + 32'd1);
  localparam int FLT_W  = $clog2(LOCK_FILTER_CYCLES + 32'd1);
  localparam int STR_W  = $clog2(SYS_RESET_STRETCH + 32'd1);

  // Each counter is compared against the value it holds in its final cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 32'd1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 32'd1);
  localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(LOCK_FILTER_CYCLES - 32'd1);
  localparam logic [STR_W-1:0]  STR_LAST  = STR_W'(SYS_RESET_STRETCH - 32'd1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRIES);
  // With a one-cycle filter, the first synchronized lock sample is enough.
  localparam bit                FLT_ONE   = (LOCK_FILTER_CYCLES == 32'd1);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              lock_meta_r;
  logic              lock_s_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TMO_W-1:0]  tmo_cnt_r;
  logic [FLT_W-1:0]  flt_cnt_r;
  logic [STR_W-1:0]  str_cnt_r;
  logic              timeout_s;
  logic              retry_inc_s;
  logic              retry_clr_s;
  logic              loss_s;
  logic              released_s;
  logic              in_acq_s;
  logic              next_acq_s;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= PLL_LOCK;
      lock_s_r    <= lock_meta_r;
    end
  end

  // State register.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus the retry and lock-loss event strobes.
  always_comb begin
    state_next_s = state_r;
    retry_inc_s  = 1'b0;
    retry_clr_s  = 1'b0;
    loss_s       = 1'b0;
    timeout_s    = (tmo_cnt_r == TMO_LAST);
    case (state_r)
      ST_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_next_s = ST_WAIT_LOCK;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_r && FLT_ONE) begin
          state_next_s = ST_RUN;
        end else if (timeout_s) begin
          if (RETRY_COUNT == RETRY_MAX) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_HOLD;
            retry_inc_s  = 1'b1;
          end
        end else if (lock_s_r) begin
          state_next_s = ST_FILTER;
        end else begin
          state_next_s = ST_WAIT_LOCK;
        end
      end
      ST_FILTER: begin
        // Acceptance takes priority over a timeout in the same cycle.
        if (lock_s_r && (flt_cnt_r == FLT_LAST)) begin
          state_next_s = ST_RUN;
        end else if (timeout_s) begin
          if (RETRY_COUNT == RETRY_MAX) begin
            state_next_s = ST_FAULT;
          end else begin
            state_next_s = ST_HOLD;
            retry_inc_s  = 1'b1;
          end
        end else if (!lock_s_r) begin
          state_next_s = ST_WAIT_LOCK;
        end else begin
          state_next_s = ST_FILTER;
        end
      end
      ST_RUN: begin
        if (!lock_s_r) begin
          state_next_s = ST_HOLD;
          loss_s       = 1'b1;
          retry_clr_s  = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        state_next_s = ST_HOLD;
      end
    endcase
  end

  // Qualifiers for the counters and registered outputs.
  always_comb begin
    in_acq_s   = (state_r == ST_WAIT_LOCK) || (state_r == ST_FILTER);
    next_acq_s = (state_next_s == ST_WAIT_LOCK) || (state_next_s == ST_FILTER);
    released_s = (state_r == ST_RUN) && (str_cnt_r == STR_LAST);
  end

  // Phase counters. Each one is cleared outside its phase and leaves the
  // phase on an equality match, so none of them can wrap.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      hold_cnt_r <= '0;
      tmo_cnt_r  <= '0;
      flt_cnt_r  <= '0;
      str_cnt_r  <= '0;
    end else begin
      if ((state_r == ST_HOLD) && (state_next_s == ST_HOLD)) begin
        hold_cnt_r <= hold_cnt_r + 1'b1;
      end else begin
        hold_cnt_r <= '0;
      end

      // The timeout spans the whole attempt, including FILTER -> WAIT_LOCK drops.
      if (in_acq_s && next_acq_s) begin
        tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end else begin
        tmo_cnt_r <= '0;
      end

      // The first high sample seen in WAIT_LOCK already counts toward the filter.
      if (state_next_s == ST_FILTER) begin
        if (state_r == ST_FILTER) begin
          flt_cnt_r <= flt_cnt_r + 1'b1;
        end else begin
          flt_cnt_r <= FLT_W'(1);
        end
      end else begin
        flt_cnt_r <= '0;
      end

      if ((state_r == ST_RUN) && (state_next_s == ST_RUN)) begin
        if (str_cnt_r != STR_LAST) begin
          str_cnt_r <= str_cnt_r + 1'b1;
        end else begin
          str_cnt_r <= str_cnt_r;
        end
      end else begin
        str_cnt_r <= '0;
      end
    end
  end

  // Registered outputs and the retry / lock-loss statistics.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      PLL_RESETB      <= 1'b0;
      SYS_RESET       <= 1'b1;
      READY           <= 1'b0;
      FAULT           <= 1'b0;
      RETRY_COUNT     <= 2'd0;
      LOCK_LOSS_COUNT <= 8'd0;
    end else begin
      PLL_RESETB <= in_acq_s || (state_r == ST_RUN);
      SYS_RESET  <= !released_s;
      READY      <= released_s;
      FAULT      <= (state_r == ST_FAULT);

      if (retry_clr_s) begin
        RETRY_COUNT <= 2'd0;
      end else if (retry_inc_s) begin
        RETRY_COUNT <= RETRY_COUNT + 2'd1;
      end else begin
        RETRY_COUNT <= RETRY_COUNT;
      end

      if (loss_s && (LOCK_LOSS_COUNT != 8'hFF)) begin
        LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT + 8'd1;
      end else begin
        LOCK_LOSS_COUNT <= LOCK_LOSS_COUNT;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//
// Directed bench for pll_lock_sequencer. The parameters are RESET_HOLD=4,
// FILTER=8, TIMEOUT=32, MAX_RETRIES=2 and STRETCH=4. Inputs change 1 ns after
// a rising edge. Outputs are sampled at the same point. The cyc variable holds
// the index of the edge just taken, and cycle 0 is the first edge that samples
// RESET low.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  logic       clk;
  logic       reset;
  logic       pll_lock;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  pll_lock_sequencer #(
    .RESET_HOLD_CYCLES  (4),
    .LOCK_FILTER_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2),
    .SYS_RESET_STRETCH  (4)
  ) dut (
    .REFERENCECLK   (clk),
    .RESET          (reset),
    .PLL_LOCK       (pll_lock),
    .PLL_RESETB     (pll_resetb),
    .SYS_RESET      (sys_reset),
    .READY          (ready),
    .FAULT          (fault),
    .RETRY_COUNT    (retry_count),
    .LOCK_LOSS_COUNT(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    cyc = -1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_resetb"}, {31'd0, pll_resetb}, 32'd0);
    chk({tag, "_sysrst"}, {31'd0, sys_reset}, 32'd1);
    chk({tag, "_ready"},  {31'd0, ready}, 32'd0);
    chk({tag, "_fault"},  {31'd0, fault}, 32'd0);
    chk({tag, "_retry"},  {30'd0, retry_count}, 32'd0);
    chk({tag, "_llc"},    {24'd0, lock_loss_count}, 32'd0);
  endtask

  task automatic wait_ready(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (ready) break;
      tick();
    end
    chk(tag, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int rises;
    int falls;
    int misses;
    int r_cyc;
    logic prev;

    reset    = 1'b1;
    pll_lock = 1'b0;

    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // Clean lock: PLL_RESETB rises at 4; lock raised before edge 15 -> READY at 28
    tick_to(3);
    chk("clean_resetb_3", {31'd0, pll_resetb}, 32'd0);
    tick_to(4);
    chk("clean_resetb_4", {31'd0, pll_resetb}, 32'd1);
    tick_to(14);
    pll_lock = 1'b1;
    tick_to(27);
    chk("clean_ready_27", {31'd0, ready}, 32'd0);
    chk("clean_sysrst_27", {31'd0, sys_reset}, 32'd1);
    tick_to(28);
    chk("clean_ready_28", {31'd0, ready}, 32'd1);
    chk("clean_sysrst_28", {31'd0, sys_reset}, 32'd0);
    chk("clean_retry", {30'd0, retry_count}, 32'd0);

    // Lock loss: PLL_LOCK falls before edge 31 -> SYS_RESET high at 34
    tick_to(30);
    pll_lock = 1'b0;
    tick_to(33);
    chk("loss_sysrst_33", {31'd0, sys_reset}, 32'd0);
    chk("loss_ready_33", {31'd0, ready}, 32'd1);
    tick_to(34);
    chk("loss_sysrst_34", {31'd0, sys_reset}, 32'd1);
    chk("loss_ready_34", {31'd0, ready}, 32'd0);
    chk("loss_resetb_34", {31'd0, pll_resetb}, 32'd0);
    chk("loss_llc_1", {24'd0, lock_loss_count}, 32'd1);
    pll_lock = 1'b1;
    wait_ready("loss_reacquire", 40);

    // 299 more losses: the count saturates at 255
    misses = 0;
    for (int k = 0; k < 299; k++) begin
      pll_lock = 1'b0;
      for (int i = 0; i < 10 && !sys_reset; i++) tick();
      if (!sys_reset) misses++;
      pll_lock = 1'b1;
      for (int i = 0; i < 40 && !ready; i++) tick();
      if (!ready) misses++;
    end
    chk("sat_bounded_waits", misses, 32'd0);
    chk("sat_llc_255", {24'd0, lock_loss_count}, 32'd255);

    // Reset in mid-stretch: lock is already high when WAIT_LOCK is entered,
    // so RUN starts 7 cycles after PLL_RESETB rises
    pll_lock = 1'b0;
    for (int i = 0; i < 10 && !sys_reset; i++) tick();
    pll_lock = 1'b1;
    for (int i = 0; i < 20 && !pll_resetb; i++) tick();
    chk("stretch_resetb_up", {31'd0, pll_resetb}, 32'd1);
    r_cyc = cyc;
    tick_to(r_cyc + 8);
    chk("stretch_sysrst_hi", {31'd0, sys_reset}, 32'd1);
    chk("stretch_llc_255", {24'd0, lock_loss_count}, 32'd255);
    reset = 1'b1;
    tick();
    chk_reset_vals("stretch_rst");
    reset = 1'b0;
    pll_lock = 1'b0;
    cyc = -1;

    // No lock: three attempts, then FAULT at 108
    do_reset();
    rises = 0;
    falls = 0;
    while (cyc < 108) begin
      prev = pll_resetb;
      tick();
      if (prev && !pll_resetb) falls++;
      if (!prev && pll_resetb) rises++;
      if (cyc == 36) chk("nolock_resetb_36", {31'd0, pll_resetb}, 32'd0);
      if (cyc == 107) chk("nolock_fault_107", {31'd0, fault}, 32'd0);
    end
    chk("nolock_fault_108", {31'd0, fault}, 32'd1);
    chk("nolock_retry", {30'd0, retry_count}, 32'd2);
    chk("nolock_rises", rises, 32'd3);
    chk("nolock_falls", falls, 32'd3);
    chk("nolock_sysrst", {31'd0, sys_reset}, 32'd1);
    pll_lock = 1'b1;
    tick_to(150);
    chk("nolock_sticky", {31'd0, fault}, 32'd1);
    chk("nolock_sticky_resetb", {31'd0, pll_resetb}, 32'd0);
    chk("nolock_sticky_retry", {30'd0, retry_count}, 32'd2);
    pll_lock = 1'b0;
    do_reset();
    chk("nolock_fault_cleared", {31'd0, fault}, 32'd0);
    chk("nolock_retry_cleared", {30'd0, retry_count}, 32'd0);

    // Glitchy lock: high for edges 10-14, low for 15-16, then high from 17 -> READY at 30
    tick_to(9);
    pll_lock = 1'b1;
    tick_to(14);
    pll_lock = 1'b0;
    tick_to(16);
    pll_lock = 1'b1;
    tick_to(23);
    chk("glitch_ready_23", {31'd0, ready}, 32'd0);
    tick_to(29);
    chk("glitch_ready_29", {31'd0, ready}, 32'd0);
    tick_to(30);
    chk("glitch_ready_30", {31'd0, ready}, 32'd1);
    chk("glitch_sysrst_30", {31'd0, sys_reset}, 32'd0);

    // Lock on retry: the second attempt's PLL_RESETB rises at 40, lock before edge 45
    pll_lock = 1'b0;
    do_reset();
    tick_to(44);
    chk("retry_resetb_44", {31'd0, pll_resetb}, 32'd1);
    chk("retry_count_1a", {30'd0, retry_count}, 32'd1);
    pll_lock = 1'b1;
    tick_to(57);
    chk("retry_ready_57", {31'd0, ready}, 32'd0);
    tick_to(58);
    chk("retry_ready_58", {31'd0, ready}, 32'd1);
    chk("retry_count_1b", {30'd0, retry_count}, 32'd1);
    tick_to(60);
    pll_lock = 1'b0;
    tick_to(63);
    chk("retry_sysrst_63", {31'd0, sys_reset}, 32'd0);
    tick_to(64);
    chk("retry_sysrst_64", {31'd0, sys_reset}, 32'd1);
    chk("retry_count_clr", {30'd0, retry_count}, 32'd0);
    chk("retry_llc", {24'd0, lock_loss_count}, 32'd1);

    // Reset mid-FILTER, then restart with lock held high -> READY at 15
    do_reset();
    tick_to(5);
    pll_lock = 1'b1;
    tick_to(10);
    reset = 1'b1;
    tick();
    chk_reset_vals("filt_rst");
    reset = 1'b0;
    cyc = -1;
    tick_to(3);
    chk("filt_resetb_3", {31'd0, pll_resetb}, 32'd0);
    tick_to(4);
    chk("filt_resetb_4", {31'd0, pll_resetb}, 32'd1);
    tick_to(14);
    chk("filt_ready_14", {31'd0, ready}, 32'd0);
    tick_to(15);
    chk("filt_ready_15", {31'd0, ready}, 32'd1);
    chk("filt_sysrst_15", {31'd0, sys_reset}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
